// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button conditioning front end.
package button_pkg;

  // Default debounce window: 10 ms of stable samples at 100 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  // Short window so simulations see several complete debounce events quickly.
  localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

  // Board clock frequency the default window was derived from.
  localparam int unsigned CLK_HZ = 100_000_000;

  // Counter width able to hold every value from 0 up to the window length.
  function automatic int cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage : button_pkg

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, debounced
// state register and a registered edge detector producing one-cycle pulses.
//
// Inputs and outputs are plain levels; there is no valid/ready handshake.
// The raw pin is asynchronous to clk and is only used through the
// synchronizer. All internal state is active-low (1 = released) so that
// reset values match an idle, unpressed button.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic but_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  // Last count value before a pending change is accepted; the counter
  // never goes past it, so there is no wrap-around.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;

  // Next-state: synchronize, count consecutive disagreeing samples, accept
  // the new level after DEBOUNCE_CYCLES of them, and flag the edge.
  always_comb begin
    s1_d     = but_n;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;

    if (s2_q == stable_q) begin
      // A single agreeing sample cancels any pending change.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Pulses are registered together with stable, so they line up with
    // the cycle in which pressed changes.
    press_pulse_d   = stable_q & ~stable_d;
    release_pulse_d = ~stable_q & stable_d;
  end

  // State registers; reset puts the channel in the released, idle state
  // and clears any in-flight pulse immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q            <= 1'b1;
      s2_q            <= 1'b1;
      stable_q        <= 1'b1;
      cnt_q           <= '0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      stable_q        <= stable_d;
      cnt_q           <= cnt_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign pressed       = ~stable_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// Conditions the raw active-low board buttons into debounced active-high
// levels plus one-cycle press and release pulses. Channels are independent
// copies of debounce_channel; simultaneous events pulse in the same cycle.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] but_n,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse
);

  // One identical conditioning channel per button.
  for (genvar i = 0; i < int'(N_BUTTONS); i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .but_n        (but_n[i]),
      .pressed      (pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with two buttons and a 4-sample window.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int NB = 2;
  localparam int DC = int'(DEBOUNCE_CYCLES_SIM);

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] but_n = '1;
  logic [NB-1:0] pressed, press_pulse, release_pulse;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BUTTONS(NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .but_n        (but_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  // ---------------- reference model / scoreboard ----------------
  // Pin history: the value seen by the debouncer at an edge is the pin
  // value captured two edges earlier. A channel changes its reported
  // level once DC consecutive samples disagree with it.
  logic [NB-1:0]     pin_q[$];
  logic [NB-1:0]     m_pressed, m_press, m_release;
  int                m_run[NB];
  logic [3*NB-1:0]   exp_q[$];
  logic [3*NB-1:0]   exp;
  int                n_cmp = 0;
  int                n_bad = 0;

  function automatic void model_reset();
    pin_q.delete();
    pin_q.push_back('1);
    pin_q.push_back('1);
    m_pressed = '0;
    m_press   = '0;
    m_release = '0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
    exp_q.delete();
  endfunction

  function automatic void model_step();
    logic [NB-1:0] samp;
    samp = pin_q.pop_front();
    pin_q.push_back(but_n);
    m_press   = '0;
    m_release = '0;
    for (int i = 0; i < NB; i++) begin
      if (!samp[i] == m_pressed[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DC) begin
          m_run[i]     = 0;
          m_pressed[i] = !m_pressed[i];
          if (m_pressed[i]) m_press[i] = 1'b1;
          else              m_release[i] = 1'b1;
        end
      end
    end
    exp_q.push_back({m_pressed, m_press, m_release});
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock; the model steps only when out of reset. Outputs are
  // sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    n_cmp++;
    if (pressed !== 2'b00) begin
      n_bad++; $display("FAIL reset_pressed: got %b want 00", pressed);
    end
    n_cmp++;
    if (press_pulse !== 2'b00) begin
      n_bad++; $display("FAIL reset_press_pulse: got %b want 00", press_pulse);
    end
    n_cmp++;
    if (release_pulse !== 2'b00) begin
      n_bad++; $display("FAIL reset_release_pulse: got %b want 00", release_pulse);
    end
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({pressed, press_pulse, release_pulse} !== exp) begin
        n_bad++; $display("FAIL idle_model: got %b want %b", {pressed, press_pulse, release_pulse}, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    but_n = 2'b10;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({pressed, press_pulse, release_pulse} !== exp) begin
        n_bad++; $display("FAIL press_model k=%0d: got %b want %b", k, {pressed, press_pulse, release_pulse}, exp);
      end
      n_cmp++;
      if (pressed !== ((k >= DC + 1) ? 2'b01 : 2'b00) || press_pulse !== ((k == DC + 1) ? 2'b01 : 2'b00)
          || release_pulse !== 2'b00) begin
        n_bad++; $display("FAIL press_timing k=%0d: got p=%b pp=%b rp=%b", k, pressed, press_pulse, release_pulse);
      end
    end
  endtask

  task automatic test_release();
    but_n = 2'b11;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({pressed, press_pulse, release_pulse} !== exp) begin
        n_bad++; $display("FAIL release_model k=%0d: got %b want %b", k, {pressed, press_pulse, release_pulse}, exp);
      end
      n_cmp++;
      if (pressed !== ((k >= DC + 1) ? 2'b00 : 2'b01) || release_pulse !== ((k == DC + 1) ? 2'b01 : 2'b00)
          || press_pulse !== 2'b00) begin
        n_bad++; $display("FAIL release_timing k=%0d: got p=%b pp=%b rp=%b", k, pressed, press_pulse, release_pulse);
      end
    end
  endtask

  task automatic test_bounce();
    logic [16:0] pattern;
    pattern = 17'b1111111111_0001000;  // bit k is but_n[0] in cycle k
    for (int k = 0; k < 17; k++) begin
      but_n = {1'b1, pattern[k]};
      tick();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({pressed, press_pulse, release_pulse} !== exp) begin
        n_bad++; $display("FAIL bounce_model k=%0d: got %b want %b", k, {pressed, press_pulse, release_pulse}, exp);
      end
      n_cmp++;
      if ({pressed, press_pulse, release_pulse} !== 6'b0) begin
        n_bad++; $display("FAIL bounce_quiet k=%0d: got %b want 000000", k, {pressed, press_pulse, release_pulse});
      end
    end
  endtask

  task automatic test_simultaneous();
    but_n = 2'b00;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({pressed, press_pulse, release_pulse} !== exp) begin
        n_bad++; $display("FAIL simul_model k=%0d: got %b want %b", k, {pressed, press_pulse, release_pulse}, exp);
      end
      if (k == DC + 1) begin
        n_cmp++;
        if (pressed !== 2'b11 || press_pulse !== 2'b11) begin
          n_bad++; $display("FAIL simul_edge: got p=%b pp=%b want 11/11", pressed, press_pulse);
        end
      end
      if (k == DC + 2) begin
        n_cmp++;
        if (pressed !== 2'b11 || press_pulse !== 2'b00) begin
          n_bad++; $display("FAIL simul_after: got p=%b pp=%b want 11/00", pressed, press_pulse);
        end
      end
    end
    but_n = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({pressed, press_pulse, release_pulse} !== exp) begin
        n_bad++; $display("FAIL simul_rel k=%0d: got %b want %b", k, {pressed, press_pulse, release_pulse}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    but_n = 2'b10;
    repeat (2) begin
      tick();
      void'(exp_q.pop_front());
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({pressed, press_pulse, release_pulse} !== 6'b0) begin
      n_bad++; $display("FAIL midrst_clear: got %b want 000000", {pressed, press_pulse, release_pulse});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({pressed, press_pulse, release_pulse} !== exp) begin
        n_bad++; $display("FAIL midrst_model k=%0d: got %b want %b", k, {pressed, press_pulse, release_pulse}, exp);
      end
      n_cmp++;
      if (pressed !== ((k >= DC + 1) ? 2'b01 : 2'b00) || press_pulse !== ((k == DC + 1) ? 2'b01 : 2'b00)) begin
        n_bad++; $display("FAIL midrst_press k=%0d: got p=%b pp=%b", k, pressed, press_pulse);
      end
    end
    but_n = 2'b11;
    repeat (8) begin
      tick();
      exp = exp_q.pop_front();
      n_cmp++;
      if ({pressed, press_pulse, release_pulse} !== exp) begin
        n_bad++; $display("FAIL midrst_rel: got %b want %b", {pressed, press_pulse, release_pulse}, exp);
      end
    end
  endtask

  task automatic test_random_stress();
    logic [NB-1:0] prev_pp, prev_rp;
    int            last_kind[NB];  // 1 = press, 2 = release
    int            hold;
    prev_pp = '0;
    prev_rp = '0;
    for (int i = 0; i < NB; i++) last_kind[i] = 2;
    for (int cyc = 0; cyc < 12000; ) begin
      but_n = NB'($urandom_range(0, (1 << NB) - 1));
      hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(DC, 3 * DC) : $urandom_range(1, DC);
      for (int h = 0; h < hold; h++) begin
        tick();
        cyc++;
        exp = exp_q.pop_front();
        n_cmp++;
        if ({pressed, press_pulse, release_pulse} !== exp) begin
          n_bad++; $display("FAIL stress_model cyc=%0d: got %b want %b", cyc, {pressed, press_pulse, release_pulse}, exp);
        end
        for (int i = 0; i < NB; i++) begin
          if (press_pulse[i] || release_pulse[i]) begin
            n_cmp++;
            if ((press_pulse[i] && (prev_pp[i] || last_kind[i] == 1)) ||
                (release_pulse[i] && (prev_rp[i] || last_kind[i] == 2)) ||
                (press_pulse[i] && release_pulse[i])) begin
              n_bad++; $display("FAIL stress_pulse ch=%0d cyc=%0d: pp=%b rp=%b last=%0d", i, cyc, press_pulse[i], release_pulse[i], last_kind[i]);
            end
            last_kind[i] = press_pulse[i] ? 1 : 2;
          end
        end
        prev_pp = press_pulse;
        prev_rp = release_pulse;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_random_stress();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_button_conditioner
